occupancy_arbiter: RTL and testbench
====================================

# occupancy_arbiter

Two-requester arbiter and sequencer for a saturating occupancy counter (slot pool of DEPTH entries). Each requester asks to push (claim a slot) or pop (release a slot) with a four-phase req/ack handshake. The block arbitrates round-robin and applies one operation per transaction. It refuses pushes when full and pops when empty, and publishes the count plus full/empty flags to the rest of the design.

## Interface
- DEPTH, 5, number of slots; count saturates in 0..DEPTH
- CW, 3, count width; must satisfy 2^CW > DEPTH
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- push_req  input  2  bit i = requester i requests push; level, held until ack/nack
- pop_req  input  2  bit i = requester i requests pop; level, held until ack/nack
- gnt  output  2  one-hot; requester currently being served (EXEC and DONE states)
- ack  output  2  bit i high = requester i's operation completed; held until its requests drop
- nack  output  2  bit i high = requester i's operation rejected (push when full / pop when empty); same hold rule as ack
- cnt  output  CW  current occupancy
- full  output  1  cnt == DEPTH
- empty  output  1  cnt == 0
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - requester i is active if push_req[i] | pop_req[i].
  - If none active, stay in IDLE.
  - If only one is active, grant it.
  - If both are active, grant the requester selected by prio (1-bit round-robin pointer).
  - Latch the granted id and op. If a requester raises push and pop together, the op is push. Go to EXEC.
- EXEC (exactly one cycle):
  - Push with cnt < DEPTH: cnt <= cnt+1, result = ok.
  - Push with cnt == DEPTH: cnt unchanged, result = reject.
  - Pop with cnt > 0: cnt <= cnt-1, result = ok.
  - Pop with cnt == 0: cnt unchanged, result = reject.
  - prio <= the other requester, whether the result is ok or reject.
  - Go to DONE.
- DONE:
  - ack[g] = 1 if result was ok; otherwise nack[g] = 1.
  - Stay while push_req[g] | pop_req[g] is high.
  - When both are low, go to IDLE; ack/nack deassert on that same edge.
- Requests from the non-granted requester are ignored until IDLE and are not lost; they are held level.
- Request changes by the granted requester after the IDLE sampling edge are ignored, except for the drop that ends DONE.
- The counter never wraps: cnt stays within 0..DEPTH at all times.
- full and empty are combinational from registered cnt. gnt, ack, nack and busy are registered/decoded from state only; they are glitch-free with respect to the inputs.
- At most one bit of gnt, ack and nack is set at once. ack and nack are never both set.

## Timing
- Reset (synchronous, wins over every other condition at the edge):
  - State = IDLE, cnt = 0, prio = 0 (requester 0 preferred), gnt = ack = nack = 0.
  - full = 0, empty = 1, busy = 0.
- Reset mid-transaction:
  - Asserted at the IDLE->EXEC edge or the EXEC edge: the transaction is abandoned with no count change.
  - Asserted in DONE: ack/nack clear, and cnt returns to 0 regardless.
- Latency, with request first sampled high at edge E0:
  - E0: IDLE->EXEC; gnt valid after E0.
  - E1: cnt/full/empty update; ack or nack high after E1.
  - Request dropped before edge Ek: ack/nack/gnt low and busy low after Ek.
  - Next request can be sampled at Ek+1.
- Throughput: minimum 3 edges per transaction (E0, E1, Ek with Ek = E2) when the requester drops immediately.
- If both requesters hold requests continuously between transactions, grants alternate 0,1,0,1.

## Test plan
- Reset, then requester 0 pushes once:
  - gnt=01 after E0; cnt=1 and ack=01 after E1.
  - Drop push_req[0]: ack=00, busy=0 next edge.
- Six pushes from requester 1 with DEPTH=5: pushes 1–5 are acked with cnt 1..5, and full=1 after the 5th. The 6th gets nack=10 with cnt staying 5.
- From empty, requester 0 pops: nack=01, cnt=0, empty stays 1; prio moves to requester 1.
- Both requesters raise push together from reset: requester 0 is served first (cnt=1). Requester 1 is served next without re-asserting (cnt=2). Both raise push again: requester 0 wins.
- Requester 0 raises push and pop simultaneously at cnt=2: treated as push, giving cnt=3 and ack=01.
- Assert reset in DONE with cnt=4 and ack high: after that edge cnt=0, ack=00, state IDLE, prio=0, and the held request is re-granted on the following edge.

Source files
------------

// File: rtl/occupancy_arbiter.sv
// Two-requester round-robin arbiter in front of a saturating occupancy counter.
// Each transaction is IDLE -> EXEC -> DONE, with a four-phase req/ack handshake per requester.
module occupancy_arbiter #(
    parameter int DEPTH = 5,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    push_req,
    input  logic [1:0]    pop_req,
    output logic [1:0]    gnt,
    output logic [1:0]    ack,
    output logic [1:0]    nack,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty,
    output logic          busy,
    output logic [1:0]    dbg_state_o,
    output logic          dbg_prio_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          prio_q;
    logic          gid_q;
    logic          op_push_q;
    logic [1:0]    gnt_q;
    logic [1:0]    ack_q;
    logic [1:0]    nack_q;

    logic [1:0]    active;
    logic          sel;
    logic [1:0]    gid_oh;

    // Only the IDLE sampling edge looks at both requesters; ties go to prio_q.
    always_comb begin
        active = push_req | pop_req;
        sel    = (active == 2'b11) ? prio_q : active[1];
        gid_oh = gid_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            gid_q     <= 1'b0;
            op_push_q <= 1'b0;
            gnt_q     <= 2'b00;
            ack_q     <= 2'b00;
            nack_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (active != 2'b00) begin
                        gid_q     <= sel;
                        op_push_q <= push_req[sel];
                        gnt_q     <= sel ? 2'b10 : 2'b01;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_push_q) begin
                        if (cnt_q != FULL_CNT) begin
                            cnt_q <= cnt_q + CW'(1);
                            ack_q <= gid_oh;
                        end else begin
                            nack_q <= gid_oh;
                        end
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CW'(1);
                            ack_q <= gid_oh;
                        end else begin
                            nack_q <= gid_oh;
                        end
                    end
                    // Pointer rotates on rejects too, so a stuck requester cannot starve the other.
                    prio_q  <= ~gid_q;
                    state_q <= DONE;
                end
                DONE: begin
                    if (!push_req[gid_q] && !pop_req[gid_q]) begin
                        gnt_q   <= 2'b00;
                        ack_q   <= 2'b00;
                        nack_q  <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign nack        = nack_q;
    assign cnt         = cnt_q;
    assign full        = (cnt_q == FULL_CNT);
    assign empty       = (cnt_q == '0);
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
    assign dbg_prio_o  = prio_q;

endmodule

// File: tb/tb_occupancy_arbiter.sv
// Directed + random bench for occupancy_arbiter: a reference model predicts each
// transaction's {gnt, ack, nack, cnt, full, empty} record into a queue, popped when ack/nack rises.
module tb_occupancy_arbiter;

    localparam int DEPTH = 5;
    localparam int CW    = 3;
    localparam int RW    = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    push_req = 2'b00;
    logic [1:0]    pop_req = 2'b00;
    logic [1:0]    gnt, ack, nack;
    logic [CW-1:0] cnt;
    logic          full, empty, busy;
    logic [1:0]    dbg_state;
    logic          dbg_prio;

    int errors = 0;
    int checks = 0;

    logic [RW-1:0] exp_q[$];
    int            model_cnt  = 0;
    logic          model_prio = 1'b0;
    logic          last_id    = 1'b0;

    occupancy_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_req   (push_req),
        .pop_req    (pop_req),
        .gnt        (gnt),
        .ack        (ack),
        .nack       (nack),
        .cnt        (cnt),
        .full       (full),
        .empty      (empty),
        .busy       (busy),
        .dbg_state_o(dbg_state),
        .dbg_prio_o (dbg_prio)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_cnt  = 0;
        model_prio = 1'b0;
    endtask

    // Driver-side prediction: decide the winner from the current request levels.
    task automatic expect_next();
        logic [1:0] act;
        logic       id;
        logic       is_push;
        logic       ok;
        logic [1:0] oh;
        act = push_req | pop_req;
        id  = (act == 2'b11) ? model_prio : act[1];
        is_push = push_req[id];
        if (is_push) begin
            ok = (model_cnt < DEPTH);
            if (ok) model_cnt++;
        end else begin
            ok = (model_cnt > 0);
            if (ok) model_cnt--;
        end
        model_prio = ~id;
        last_id = id;
        oh = id ? 2'b10 : 2'b01;
        exp_q.push_back({oh, ok ? oh : 2'b00, ok ? 2'b00 : oh, CW'(model_cnt),
                         model_cnt == DEPTH, model_cnt == 0});
    endtask

    // Scoreboard: pop and compare when the DUT reports a result.
    task automatic wait_done(input string tag);
        logic [RW-1:0] e;
        bit seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((ack | nack) != 2'b00) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s: got no ack/nack expected one within 10 cycles", tag);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: got unexpected result expected empty scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {21'd0, gnt, ack, nack, cnt, full, empty}, {21'd0, e});
        end
    endtask

    task automatic drop(input string tag);
        push_req[last_id] = 1'b0;
        pop_req[last_id]  = 1'b0;
        @(negedge clk);
        chk(tag, {28'd0, gnt, ack, nack} == 0 ? {31'd0, busy} : 32'hdead, 32'd0);
    endtask

    initial begin
        logic [1:0] pu, po;

        // Reset state
        do_reset();
        chk("rst_cnt", cnt, 0);
        chk("rst_flags", {full, empty, busy}, 3'b010);
        chk("rst_hs", {gnt, ack, nack}, 6'b0);
        chk("rst_state", dbg_state, 0);
        chk("rst_prio", dbg_prio, 0);

        // Single push from requester 0, with latency checks
        push_req = 2'b01;
        expect_next();
        @(negedge clk);
        chk("e0_gnt", gnt, 2'b01);
        chk("e0_cnt", cnt, 0);
        chk("e0_busy", busy, 1);
        wait_done("push0");
        drop("push0_drop");

        // Six pushes from requester 1: fill to DEPTH then reject
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_req = 2'b10;
            expect_next();
            wait_done($sformatf("fill%0d", i));
            drop($sformatf("fill%0d_drop", i));
        end

        // Pop from empty is rejected and still rotates priority
        do_reset();
        pop_req = 2'b01;
        expect_next();
        wait_done("pop_empty");
        drop("pop_empty_drop");
        chk("pop_empty_prio", dbg_prio, 1);

        // Simultaneous pushes: 0, then 1 without re-assertion, then 0 again
        do_reset();
        push_req = 2'b11;
        expect_next();
        wait_done("both_a");
        drop("both_a_drop");
        expect_next();
        wait_done("both_b");
        drop("both_b_drop");
        push_req = 2'b11;
        expect_next();
        chk("both_c_winner", last_id, 0);
        wait_done("both_c");
        drop("both_c_drop");
        push_req = 2'b00;
        @(negedge clk);

        // Push+pop together counts as push (cnt 2 -> 3)
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_req = 2'b01;
            expect_next();
            wait_done("pre_pp");
            drop("pre_pp_drop");
        end
        push_req = 2'b01;
        pop_req  = 2'b01;
        expect_next();
        wait_done("push_pop");
        drop("push_pop_drop");

        // Reset while in DONE at cnt=4 with ack held
        push_req = 2'b10;
        expect_next();
        wait_done("to_four");
        chk("four_cnt", cnt, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_cnt  = 0;
        model_prio = 1'b0;
        exp_q.delete();
        chk("rd_cnt", cnt, 0);
        chk("rd_hs", {gnt, ack, nack}, 6'b0);
        chk("rd_state", dbg_state, 0);
        chk("rd_prio", dbg_prio, 0);
        expect_next();
        @(negedge clk);
        chk("rd_regrant", gnt, 2'b10);
        wait_done("rd_txn");
        drop("rd_drop");

        // Random mix of both requesters; non-granted requests stay held
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ((push_req | pop_req) == 2'b00) begin
                pu = 2'($urandom_range(0, 3));
                po = 2'($urandom_range(0, 3));
                if ((pu | po) == 2'b00) pu = 2'b01;
                push_req = pu;
                pop_req  = po;
            end
            expect_next();
            wait_done($sformatf("rnd%0d", n));
            drop($sformatf("rnd%0d_drop", n));
        end
        push_req = 2'b00;
        pop_req  = 2'b00;
        @(negedge clk);
        chk("final_idle", busy, 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
